// File: rtl/lut_stream_engine.sv
// rtl/lut_stream_engine.sv - two-stage valid/ready stream through a programmable lookup table
module lut_stream_engine #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tbl_we,
    input  logic [IN_W-1:0]  tbl_addr,
    input  logic [OUT_W-1:0] tbl_wdata,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] tbl [0:DEPTH-1];

    logic            adv;
    logic            accept;
    logic            s1_valid;
    logic [IN_W-1:0] s1_addr;
    logic            s1_byp;

    // Whole pipeline moves together; an empty stage 1 still holds during a stall.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Table is deliberately unreset; the stage-2 read below sees the pre-edge value on a collision.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl[tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_byp    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            s1_valid  <= accept;
            s1_addr   <= in_data;
            s1_byp    <= in_bypass;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_byp ? OUT_W'(s1_addr) : tbl[s1_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lut_stream_engine.sv
// tb/tb_lut_stream_engine.sv - directed self-checking bench for lut_stream_engine
module tb_lut_stream_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tbl_we;
    logic [7:0]  tbl_addr;
    logic [7:0]  tbl_wdata;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_bypass;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] out_count;

    logic        w_rst_n;
    logic        w_tbl_we;
    logic [7:0]  w_tbl_addr;
    logic [11:0] w_tbl_wdata;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [7:0]  w_in_data;
    logic        w_in_bypass;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [11:0] w_out_data;
    logic [3:0]  w_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_stream_engine #(.IN_W(8), .OUT_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bypass(in_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    lut_stream_engine #(.IN_W(8), .OUT_W(12), .CNT_W(4)) u_wide (
        .clk(clk), .rst_n(w_rst_n), .tbl_we(w_tbl_we), .tbl_addr(w_tbl_addr), .tbl_wdata(w_tbl_wdata),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_bypass(w_in_bypass),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_count(w_out_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vals [20] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'hA5, 8'h5A, 8'h7F,
                              8'h10, 8'hEE, 8'h42, 8'h99, 8'h02, 8'hFE, 8'h33, 8'hC0,
                              8'h0F, 8'hF0, 8'h6B, 8'hD4};
    logic [7:0]  e8;
    logic [11:0] e12;

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b1;
        w_tbl_we = 1'b0; w_tbl_addr = '0; w_tbl_wdata = '0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_bypass = 1'b0; w_out_ready = 1'b1;
        step;
        step;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1; w_rst_n = 1'b1;
        step;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // program table[a] = ~a
        for (int a = 0; a < 256; a++) begin
            tbl_we = 1'b1; tbl_addr = 8'(a); tbl_wdata = ~8'(a);
            step;
        end
        tbl_we = 1'b0;

        // back-to-back stream of 20
        for (int i = 0; i < 22; i++) begin
            in_valid = (i < 20);
            if (i < 20) in_data = vals[i];
            step;
            if (i == 0) begin
                check("latency_first_edge", 32'(out_valid), 32'd0);
            end else if (i <= 20) begin
                e8 = ~vals[i-1];
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(e8));
            end else begin
                check("stream_drained", 32'(out_valid), 32'd0);
            end
        end
        check("stream_count", 32'(out_count), 32'd20);

        // stall with in_valid held high
        in_valid = 1'b1; in_data = 8'h3C;
        step;
        out_ready = 1'b0;
        step;
        for (int i = 0; i < 5; i++) begin
            step;
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'hC3);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        check("stall_count", 32'(out_count), 32'd20);
        out_ready = 1'b1; in_valid = 1'b0;
        step;
        check("unstall_1_valid", 32'(out_valid), 32'd1);
        check("unstall_1_data", 32'(out_data), 32'hC3);
        check("unstall_1_count", 32'(out_count), 32'd21);
        step;
        check("unstall_2_valid", 32'(out_valid), 32'd0);
        check("unstall_2_count", 32'(out_count), 32'd22);

        // read-before-write collision on address 0x55
        tbl_we = 1'b1; tbl_addr = 8'h55; tbl_wdata = 8'h55;
        in_valid = 1'b1; in_data = 8'h55;
        step;
        in_valid = 1'b0; tbl_wdata = 8'hAA;
        step;
        tbl_we = 1'b0;
        check("collide_valid", 32'(out_valid), 32'd1);
        check("collide_old", 32'(out_data), 32'h55);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        check("collide_new", 32'(out_data), 32'hAA);
        out_ready = 1'b0;
        tbl_we = 1'b1; tbl_wdata = 8'h00;
        step;
        tbl_we = 1'b0;
        check("write_keeps_held_data", 32'(out_data), 32'hAA);
        out_ready = 1'b1;
        step;
        check("collide_count", 32'(out_count), 32'd24);
        tbl_we = 1'b1; tbl_wdata = 8'hAA;
        step;
        tbl_we = 1'b0;

        // wide instance: bypass resize and 4-bit counter wrap
        for (int i = 0; i < 19; i++) begin
            w_in_valid = (i < 17); w_in_bypass = 1'b1; w_in_data = 8'h81 + 8'(i);
            step;
            if (i >= 1 && i <= 17) begin
                e12 = {4'h0, 8'h81 + 8'(i - 1)};
                check("bypass_data", 32'(w_out_data), 32'(e12));
            end
            if (i == 16) check("wrap_cnt_15", 32'(w_out_count), 32'd15);
            if (i == 17) check("wrap_cnt_0", 32'(w_out_count), 32'd0);
            if (i == 18) check("wrap_cnt_1", 32'(w_out_count), 32'd1);
        end
        w_in_valid = 1'b0;
        w_tbl_we = 1'b1; w_tbl_addr = 8'h81; w_tbl_wdata = 12'hABC;
        step;
        w_tbl_we = 1'b0;
        w_in_valid = 1'b1; w_in_data = 8'h81; w_in_bypass = 1'b0;
        step;
        w_in_bypass = 1'b1;
        step;
        w_in_valid = 1'b0;
        check("wide_lookup", 32'(w_out_data), 32'hABC);
        step;
        check("wide_bypass_ignores_tbl", 32'(w_out_data), 32'h081);
        step;

        // asynchronous reset with two samples in flight
        in_valid = 1'b1; in_data = 8'h10;
        step;
        in_data = 8'h20;
        step;
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        step;
        check("after_rst_no_ghost", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h77;
        step;
        in_valid = 1'b0;
        step;
        check("after_rst_valid", 32'(out_valid), 32'd1);
        check("after_rst_table", 32'(out_data), 32'h88);
        step;
        check("after_rst_count", 32'(out_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_stream_engine.md
Name: lut_stream_engine

Overview:
- Parametrised, pipelined successor to the fixed 8-bit combinational LUT blocks.
- A programmable lookup table of 2**IN_W entries × OUT_W bits is written through a table port.
- Input samples are streamed through the table with valid/ready handshakes at a fixed 2-cycle latency.
- Adds a per-sample bypass mode and a processed-sample counter, so benches and the top level can run random-entry sweeps without combinational timing.

Parameters:
- IN_W, 8, sample/address width; table depth = 2**IN_W.
- OUT_W, 8, table entry and output width.
- CNT_W, 16, width of processed-sample counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  IN_W  table write address.
- tbl_wdata  in  OUT_W  table write data.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept a sample this cycle.
- in_data  in  IN_W  input sample (table address).
- in_bypass  in  1  per-sample mode: 1 = output zero-extended/truncated in_data, 0 = table lookup.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  OUT_W  result.
- out_count  out  CNT_W  number of completed output handshakes, modulo 2**CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid, out_valid, out_data and out_count are all 0.
  - in_ready is 1 one cycle after deassertion, and combinationally 1 while the pipeline is empty.
  - Table contents are NOT reset; they are undefined until written.
- Pipeline advance: adv = !out_valid | out_ready. in_ready = adv (combinational).
- Input acceptance: a sample is accepted when in_valid & in_ready.
- Stage 1, on adv: s1_valid <= accept; s1_addr <= in_data; s1_byp <= in_bypass.
- Stage 2, on adv: out_valid <= s1_valid.
  - When s1_valid is set, out_data <= s1_byp ? resize(s1_addr) : table[s1_addr].
  - resize means zero-extend if OUT_W > IN_W and keep the low bits if OUT_W < IN_W.
- Latency: an accepted sample appears on out_valid 2 cycles after acceptance when there is no backpressure.
- Throughput: 1 sample/cycle with out_ready held high.
- Stall (out_valid & !out_ready):
  - Both stages hold; in_ready = 0.
  - out_data is stable and the table is not re-read for the held sample.
- Bubbles are not collapsed: a stall holds stage 1 even when it is empty.
- Table write: tbl_we writes table[tbl_addr] <= tbl_wdata at the clock edge and is accepted in every cycle, including during stalls and streaming.
- Write/lookup collision (same address, same edge that stage 2 reads): read-before-write; out_data gets the OLD entry and the new value is visible from the next lookup.
- Writes never change an out_data value that has already been registered.
- out_count increments on out_valid & out_ready and wraps from 2**CNT_W-1 to 0.
- No other state. There are no error conditions: every address is in range by construction.
- Reset mid-stream: in-flight samples are discarded, out_valid drops immediately (async), and the counter returns to 0. Table contents persist.

Test Plan:
- Program table[a] = ~a (IN_W = OUT_W = 8), then stream 20 random entries back-to-back with out_ready = 1 -> after 2 cycles, one result per cycle, each equal to ~input, in order; out_count = 20.
- Hold out_ready = 0 for 5 cycles while in_valid = 1 with in_data = 8'h3C -> out_valid stays 1, out_data holds 8'hC3, in_ready = 0; no sample is lost or duplicated when out_ready returns.
- Write table[8'h55] = 8'hAA on the same edge that stage 2 reads address 8'h55 (old value 8'hAA^8'hFF) -> output is 8'h55 (old); the next lookup of 8'h55 returns 8'hAA.
- Stream with in_bypass = 1, in_data = 8'h81 and IN_W = 8, OUT_W = 12 -> out_data = 12'h081, table ignored.
- Assert rst_n low for 1 ns with 2 samples in flight -> out_valid drops immediately and out_count = 0; after release, table[a] = ~a still returns correct results.
- CNT_W = 4: complete 17 handshakes -> out_count reads 15 after 15 handshakes, 0 after 16, and 1 after 17.
